// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : RV32I load/store funct3 codes, LSU state encoding, decode helpers
// Revision : 1.0
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MERGE = 2'd1,
        RESP  = 2'd2
    } lsu_state_e;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (we) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if ((f3 == F3_H) || (f3 == F3_HU)) begin
            mis = off[0];
        end else if (f3 == F3_W) begin
            mis = |off;
        end
        return mis;
    endfunction

    // Halfword accesses drop bit 0, word accesses drop bits 1:0.
    function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
        logic [1:0] res;
        res = off;
        if ((f3 == F3_H) || (f3 == F3_HU)) begin
            res = {off[1], 1'b0};
        end else if (f3 == F3_W) begin
            res = 2'b00;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Brief    : Combinational lane extract/extend for loads and lane merge for stores
// Revision : 1.0
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_off)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_load_data = i_word;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'h0, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'h0, w_half};
            default: o_load_data = i_word;
        endcase
    end

    // Store size is carried by funct3[1:0]; the old word supplies untouched lanes.
    always_comb begin
        o_store_word = i_word;
        case (i_funct3[1:0])
            2'b00: begin
                case (i_off)
                    2'd0:    o_store_word = {i_word[31:8], i_wdata[7:0]};
                    2'd1:    o_store_word = {i_word[31:16], i_wdata[7:0], i_word[7:0]};
                    2'd2:    o_store_word = {i_word[31:24], i_wdata[7:0], i_word[15:0]};
                    default: o_store_word = {i_wdata[7:0], i_word[23:0]};
                endcase
            end
            2'b01: begin
                o_store_word = i_off[1] ? {i_wdata[15:0], i_word[15:0]}
                                        : {i_word[31:16], i_wdata[15:0]};
            end
            default: o_store_word = i_wdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_dmem_master.sv
`default_nettype none
// ============================================================================
// Module   : lsu_dmem_master
// Brief    : RV32I load/store initiator to a word-addressed data memory, with
//            read-modify-write for SB/SH. LSU_MISALIGN_TRAP_EN turns misaligned
//            accesses into errors instead of silently aligning them down.
// Revision : 1.0
// ============================================================================
module lsu_dmem_master
    import lsu_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int IDX_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [29:0] c_depth = 30'(MEM_DEPTH);

    lsu_state_e  r_state_q, w_state_d;
    logic [31:0] r_addr_q,  w_addr_d;
    logic [31:0] r_wdata_q, w_wdata_d;
    logic [31:0] r_old_q,   w_old_d;
    logic [2:0]  r_f3_q,    w_f3_d;
    logic [31:0] r_rdata_q, w_rdata_d;
    logic        r_err_q,   w_err_d;

    logic        w_f3_ok;
    logic        w_oor;
    logic        w_mis;
    logic        w_req_err;
    logic [1:0]  w_eff_off;
    logic [IDX_W-1:0] w_idx;

    logic [31:0] w_al_word;
    logic [31:0] w_al_wdata;
    logic [1:0]  w_al_off;
    logic [2:0]  w_al_f3;
    logic [31:0] w_load_data;
    logic [31:0] w_store_word;

    assign w_idx   = req_addr[IDX_W+1:2];
    assign w_oor   = (|req_addr[31:IDX_W+2]) ||
                     ({{(30-IDX_W){1'b0}}, w_idx} >= c_depth);
    assign w_f3_ok = f3_legal(req_we, req_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_mis     = f3_misaligned(req_funct3, req_addr[1:0]);
    assign w_eff_off = req_addr[1:0];
`else
    assign w_mis     = 1'b0;
    assign w_eff_off = align_off(req_funct3, req_addr[1:0]);
`endif

    assign w_req_err = !w_f3_ok || w_oor || w_mis;

    // One aligner serves both paths: live memory data while IDLE, the
    // captured old word while merging.
    always_comb begin
        if (r_state_q == MERGE) begin
            w_al_word  = r_old_q;
            w_al_wdata = r_wdata_q;
            w_al_off   = r_addr_q[1:0];
            w_al_f3    = r_f3_q;
        end else begin
            w_al_word  = mem_rd;
            w_al_wdata = req_wdata;
            w_al_off   = w_eff_off;
            w_al_f3    = req_funct3;
        end
    end

    lsu_lane_align u_lane_align (
        .i_word       (w_al_word),
        .i_wdata      (w_al_wdata),
        .i_off        (w_al_off),
        .i_funct3     (w_al_f3),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_addr_d   = r_addr_q;
        w_wdata_d  = r_wdata_q;
        w_old_d    = r_old_q;
        w_f3_d     = r_f3_q;
        w_rdata_d  = r_rdata_q;
        w_err_d    = r_err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_wd     = 32'h0;
        mem_a      = {r_addr_q[31:2], 2'b00};

        case (r_state_q)
            IDLE: begin
                req_ready = 1'b1;
                mem_a     = {req_addr[31:2], 2'b00};
                if (req_valid) begin
                    w_addr_d = {req_addr[31:2], w_eff_off};
                    w_f3_d   = req_funct3;
                    if (w_req_err) begin
                        w_err_d   = 1'b1;
                        w_rdata_d = 32'h0;
                        w_state_d = RESP;
                    end else if (!req_we) begin
                        w_err_d   = 1'b0;
                        w_rdata_d = w_load_data;
                        w_state_d = RESP;
                    end else if (req_funct3 == F3_W) begin
                        mem_we    = 1'b1;
                        mem_wd    = req_wdata;
                        w_err_d   = 1'b0;
                        w_rdata_d = 32'h0;
                        w_state_d = RESP;
                    end else begin
                        w_old_d   = mem_rd;
                        w_wdata_d = req_wdata;
                        w_state_d = MERGE;
                    end
                end
            end
            MERGE: begin
                mem_we    = 1'b1;
                mem_wd    = w_store_word;
                w_err_d   = 1'b0;
                w_rdata_d = 32'h0;
                w_state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                w_state_d  = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // mem_we decodes from r_state_q, so an async reset mid-MERGE kills the write at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= IDLE;
            r_addr_q  <= 32'h0;
            r_wdata_q <= 32'h0;
            r_old_q   <= 32'h0;
            r_f3_q    <= 3'b000;
            r_rdata_q <= 32'h0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_addr_q  <= w_addr_d;
            r_wdata_q <= w_wdata_d;
            r_old_q   <= w_old_d;
            r_f3_q    <= w_f3_d;
            r_rdata_q <= w_rdata_d;
            r_err_q   <= w_err_d;
        end
    end

    assign resp_rdata = r_rdata_q;
    assign resp_err   = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_dmem_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_dmem_master
// Brief    : Scoreboard bench for lsu_dmem_master against a small word memory
// Revision : 1.0
// ============================================================================
module tb_lsu_dmem_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:255];
    logic        preload;

    int cyc      = 0;
    int last_acc = 0;
    int checks   = 0;
    int errors   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } resp_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
    } wr_exp_t;

    resp_exp_t resp_q[$];
    wr_exp_t   wr_q[$];

    lsu_dmem_master #(.MEM_DEPTH(256), .IDX_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rd = (mem_a[31:10] == 22'h0) ? mem[mem_a[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i == 4) ? 32'h8899AABB : 32'h0;
        end else if (mem_we && (mem_a[31:10] == 22'h0)) begin
            mem[mem_a[9:2]] <= mem_wd;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops scoreboard entries whenever the DUT writes memory or responds.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid && req_ready) last_acc = cyc;
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    flag("unexpected_mem_we");
                end else begin
                    wr_exp_t w;
                    w = wr_q.pop_front();
                    chk("mem_a", mem_a, w.addr);
                    chk("mem_wd", mem_wd, w.data);
                    chk("mem_we_latency", 32'(cyc - last_acc), 32'(w.lat));
                end
            end
            if (resp_valid) begin
                if (resp_q.size() == 0) begin
                    flag("unexpected_resp_valid");
                end else begin
                    resp_exp_t r;
                    r = resp_q.pop_front();
                    chk("resp_rdata", resp_rdata, r.rdata);
                    chk("resp_err", {31'h0, resp_err}, {31'h0, r.err});
                    chk("resp_latency", 32'(cyc - last_acc), 32'(r.lat));
                    chk("req_ready_in_resp", {31'h0, req_ready}, 32'h0);
                end
            end
        end
    end

    // Called at posedge+1; returns at the posedge+1 after acceptance.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] erd, input logic eerr,
                         input int elat, input logic ewr, input logic [31:0] wa,
                         input logic [31:0] wd, input int wlat);
        int n;
        resp_exp_t r;
        wr_exp_t   w;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            flag("req_ready_timeout");
        end else begin
            r.rdata = erd; r.err = eerr; r.lat = elat;
            resp_q.push_back(r);
            if (ewr) begin
                w.addr = wa; w.data = wd; w.lat = wlat;
                wr_q.push_back(w);
            end
            req_valid  = 1'b1;
            req_we     = we;
            req_funct3 = f3;
            req_addr   = addr;
            req_wdata  = wdata;
            @(posedge clk); #1;
            req_valid  = 1'b0;
        end
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] erd, input logic eerr);
        issue(1'b0, f3, addr, 32'h0, erd, eerr, 1, 1'b0, 32'h0, 32'h0, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (resp_q.size() != 0 || wr_q.size() != 0) begin
            flag("drain_timeout");
            resp_q.delete();
            wr_q.delete();
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        preload    = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("reset_resp_rdata", resp_rdata, 32'h0);
        chk("reset_resp_err", {31'h0, resp_err}, 32'h0);
        chk("reset_mem_we", {31'h0, mem_we}, 32'h0);
        preload = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_req_ready", {31'h0, req_ready}, 32'h1);

        load(3'b000, 32'h11, 32'hFFFFFFAA, 1'b0);
        load(3'b100, 32'h11, 32'h000000AA, 1'b0);
        load(3'b001, 32'h12, 32'hFFFF8899, 1'b0);
        load(3'b010, 32'h10, 32'h8899AABB, 1'b0);

        issue(1'b1, 3'b000, 32'h12, 32'h12345655, 32'h0, 1'b0, 2, 1'b1, 32'h10, 32'h8855AABB, 1);
        load(3'b010, 32'h10, 32'h8855AABB, 1'b0);

        issue(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 1, 1'b1, 32'h20, 32'hDEADBEEF, 0);
        load(3'b101, 32'h22, 32'h0000DEAD, 1'b0);
        load(3'b000, 32'h20, 32'hFFFFFFEF, 1'b0);
        issue(1'b1, 3'b001, 32'h22, 32'h00007777, 32'h0, 1'b0, 2, 1'b1, 32'h20, 32'h7777BEEF, 1);
        load(3'b010, 32'h20, 32'h7777BEEF, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
        load(3'b001, 32'h13, 32'h0, 1'b1);
        issue(1'b1, 3'b010, 32'h25, 32'hCAFEF00D, 32'h0, 1'b1, 1, 1'b0, 32'h0, 32'h0, 0);
        load(3'b010, 32'h24, 32'h0, 1'b0);
`else
        load(3'b001, 32'h13, 32'hFFFF8855, 1'b0);
        issue(1'b1, 3'b010, 32'h25, 32'hCAFEF00D, 32'h0, 1'b0, 1, 1'b1, 32'h24, 32'hCAFEF00D, 0);
        load(3'b010, 32'h24, 32'hCAFEF00D, 1'b0);
`endif

        load(3'b011, 32'h10, 32'h0, 1'b1);
        load(3'b010, 32'h400, 32'h0, 1'b1);
        load(3'b010, 32'h3FC, 32'h0, 1'b0);
        issue(1'b1, 3'b100, 32'h20, 32'h11111111, 32'h0, 1'b1, 1, 1'b0, 32'h0, 32'h0, 0);
        load(3'b010, 32'h20, 32'h7777BEEF, 1'b0);
        drain();

        // Reset lands while the SH merge write is being presented.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h10;
        req_wdata  = 32'h00001234;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        chk("merge_mem_we_before_reset", {31'h0, mem_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("merge_reset_mem_we", {31'h0, mem_we}, 32'h0);
        chk("merge_reset_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("merge_reset_resp_rdata", resp_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("merge_reset_mem_word", mem[4], 32'h8855AABB);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_req_ready", {31'h0, req_ready}, 32'h1);
        chk("post_reset_resp_valid", {31'h0, resp_valid}, 32'h0);
        load(3'b010, 32'h10, 32'h8855AABB, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
